sumator_cla_pipe: RTL and testbench
===================================

# sumator_cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit P/G lookahead slices. It accepts WIDTH-bit operands through a valid/ready handshake and processes STAGE_BITS bits per pipeline stage, passing the carry between stages. Results carry sum, carry-out, signed-overflow and zero flags. It is the registered, width-scalable successor to the team's 16-bit lookahead adder and sits between operand registers and the result bus of the datapath.

## Interface
- WIDTH, 16: operand/result width. Must be a multiple of STAGE_BITS.
- STAGE_BITS, 8: bits resolved per pipeline stage. Must be a multiple of 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low; the single clock and asynchronous active-low reset are fixed.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B; 1: A−B, computed as A+~B+1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  out  1  sum == 0.

## Operation
- L = WIDTH/STAGE_BITS stages. Stage k resolves bits [k·STAGE_BITS +: STAGE_BITS] using STAGE_BITS/4 slices, with group P/G lookahead across the slices in the stage.
- Stage 0 uses cin = sub and b_eff = sub ? ~b : b.
- Each stage register holds:
  - valid bit,
  - sum bits resolved so far,
  - stage carry-out,
  - unresolved upper bits of a and b_eff,
  - carry into the current MSB position. This is needed for ovf in the last stage.
- Global stall: advance = ~out_valid | out_ready. All stage registers load only when advance = 1.
- in_ready = advance, purely combinational from out_valid/out_ready.
- A beat is accepted when in_valid & in_ready. A stage whose input has no valid beat loads valid = 0; bubbles are not collapsed.
- Output registers are the last stage. sum, cout, ovf and zero hold stable while out_valid & ~out_ready.
- Results emerge in acceptance order. There is no drop and no duplication.

## Timing
- Reset: all valid bits, sum, cout, ovf and zero are 0. out_valid = 0 and in_ready = 1 immediately while rst_n = 0 and after release.
- Latency:
  - A beat accepted at edge n has out_valid = 1 after edge n+L−1. With the defaults, the result is visible in the cycle after the accept edge plus one (2 cycles total for L = 2).
  - Equivalently, the output is registered L edges after the accepting edge counts as edge 1.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Stall: with out_valid & ~out_ready, in_ready = 0 in the same cycle and all stages freeze.
- Same-cycle output handoff and new accept are allowed: out_ready = 1 with in_valid = 1 advances the whole pipe.
- Width wrap: 0xFFFF+1 gives sum 0, cout 1. Overflow does not saturate.
- Reset mid-operation: in-flight beats are discarded and all outputs return to reset values asynchronously.
- in_valid with in_ready = 0 has no effect. a, b and sub are sampled only on the accept edge.

## Structure
- Shared package sumator_pkg holds:
  - localparam SLICE_BITS = 4,
  - a function computing 4-bit slice P/G,
  - a function combining P/G across slices for a stage carry.
- Sub-module cla4_pg_slice: combinational 4-bit lookahead slice.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], P (AND of a|b), G (group generate).
  - Instantiated STAGE_BITS/4 times per stage via generate.
- Top module contains the generate loop over stages, stage registers and the stall logic. It has no FSM beyond per-stage valid bits.

## Test plan
- Reset: hold rst_n = 0 with random inputs. Required: out_valid = sum = cout = ovf = zero = 0 and in_ready = 1. Then release rst_n; these values hold until the first accept.
- Add carry across the stage boundary: 0x00FF + 0x0001, sub = 0, WIDTH = 16, STAGE_BITS = 8. Required: sum = 0x0100, cout = 0, ovf = 0, zero = 0, with out_valid exactly L = 2 edges after accept.
- Wrap: 0xFFFF + 0x0001, sub = 0. Required: sum = 0x0000, cout = 1, ovf = 0, zero = 1.
- Signed subtract overflow: 0x8000 − 0x0001, sub = 1. Required: sum = 0x7FFF, cout = 1, ovf = 1. Also 0x0003 − 0x0005 gives sum = 0xFFFE, cout = 0, ovf = 0.
- Back-pressure: stream 6 back-to-back beats with out_ready = 0 for 3 cycles mid-stream. Required:
  - in_ready = 0 throughout the stall,
  - all 6 results in order, none lost or repeated,
  - outputs stable during the stall.
- Reset mid-flight: assert rst_n = 0 with 2 beats in the pipe. Required: out_valid drops to 0 without waiting for clk, and no stale result appears after release. Also repeat the add tests with WIDTH = 32, STAGE_BITS = 4 (L = 8) against a reference model over 10k random beats.

Source files
------------

// File: rtl/sumator_pkg.sv
// Shared definitions for the pipelined lookahead adder: slice width and the
// propagate/generate helpers used inside a slice and across slices of a stage.
package sumator_pkg;

    localparam int SLICE_BITS = 4;
    localparam int MAX_SLICES = 16;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Group P is the AND of inclusive-OR propagates, which is sufficient for carries.
    function automatic pg_t slice_pg(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] pi;
        logic [3:0] gi;
        pg_t        r;
        pi  = a | b;
        gi  = a & b;
        r.p = &pi;
        r.g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
            | (pi[3] & pi[2] & pi[1] & gi[0]);
        return r;
    endfunction

    function automatic logic group_carry(input logic [MAX_SLICES-1:0] p,
                                         input logic [MAX_SLICES-1:0] g,
                                         input logic                  cin,
                                         input int                    n);
        logic c;
        c = cin;
        for (int i = 0; i < MAX_SLICES; i++) begin
            if (i < n) c = g[i] | (p[i] & c);
        end
        return c;
    endfunction

endpackage

// File: rtl/cla4_pg_slice.sv
// Combinational 4-bit carry-lookahead slice exporting group propagate/generate.
module cla4_pg_slice
    import sumator_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);

    logic [3:0] pi;
    logic [3:0] gi;
    logic [3:0] c;
    pg_t        pg;

    assign pi   = a | b;
    assign gi   = a & b;
    assign c[0] = cin;
    assign c[1] = gi[0] | (pi[0] & cin);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & cin);
    assign sum  = a ^ b ^ c;
    assign pg   = slice_pg(a, b);
    assign p    = pg.p;
    assign g    = pg.g;

endmodule

// File: rtl/sumator_cla_pipe.sv
// Pipelined adder/subtractor: each stage resolves STAGE_BITS bits with 4-bit
// lookahead slices and hands its carry to the next stage; one global stall.
module sumator_cla_pipe
    import sumator_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int L  = WIDTH / STAGE_BITS;
    localparam int NS = STAGE_BITS / SLICE_BITS;
    localparam logic [WIDTH-1:0] STAGE_MASK = WIDTH'({STAGE_BITS{1'b1}});

    logic             advance;
    logic             vld_p [L];
    logic [WIDTH-1:0] sum_p [L];
    logic [WIDTH-1:0] a_p   [L];
    logic [WIDTH-1:0] b_p   [L];
    logic             cy_p  [L];
    logic             cm_p  [L];
    logic             zero_p;

    logic             vin_c   [L];
    logic [WIDTH-1:0] sa_c    [L];
    logic [WIDTH-1:0] sb_c    [L];
    logic [WIDTH-1:0] sin_c   [L];
    logic [WIDTH-1:0] snext_c [L];
    logic             cin_c   [L];
    logic             cout_c  [L];
    logic             cm_c    [L];

    assign advance  = ~vld_p[L-1] | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < L; k++) begin : g_stage
        logic [NS-1:0]         p;
        logic [NS-1:0]         g;
        logic [NS-1:0]         c;
        logic [STAGE_BITS-1:0] s;

        if (k == 0) begin : g_head
            assign vin_c[k] = in_valid;
            assign sa_c[k]  = a;
            assign sb_c[k]  = sub ? ~b : b;
            assign cin_c[k] = sub;
            assign sin_c[k] = '0;
        end else begin : g_body
            assign vin_c[k] = vld_p[k-1];
            assign sa_c[k]  = a_p[k-1];
            assign sb_c[k]  = b_p[k-1];
            assign cin_c[k] = cy_p[k-1];
            assign sin_c[k] = sum_p[k-1];
        end

        for (genvar j = 0; j < NS; j++) begin : g_slice
            assign c[j] = group_carry(MAX_SLICES'(p), MAX_SLICES'(g), cin_c[k], j);
            cla4_pg_slice u_slice (
                .a   (sa_c[k][k*STAGE_BITS + j*SLICE_BITS +: SLICE_BITS]),
                .b   (sb_c[k][k*STAGE_BITS + j*SLICE_BITS +: SLICE_BITS]),
                .cin (c[j]),
                .sum (s[j*SLICE_BITS +: SLICE_BITS]),
                .p   (p[j]),
                .g   (g[j])
            );
        end

        assign cout_c[k]  = group_carry(MAX_SLICES'(p), MAX_SLICES'(g), cin_c[k], NS);
        // Carry into this stage's top bit recovered from its sum bit.
        assign cm_c[k]    = s[STAGE_BITS-1] ^ sa_c[k][k*STAGE_BITS + STAGE_BITS-1]
                          ^ sb_c[k][k*STAGE_BITS + STAGE_BITS-1];
        assign snext_c[k] = (sin_c[k] & ~(STAGE_MASK << (k*STAGE_BITS)))
                          | (WIDTH'(s) << (k*STAGE_BITS));
    end

    // Stage registers: valid and flags are reset; payload loads only with a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < L; k++) begin
                vld_p[k] <= 1'b0;
                sum_p[k] <= '0;
                cy_p[k]  <= 1'b0;
                cm_p[k]  <= 1'b0;
            end
            zero_p <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < L; k++) begin
                vld_p[k] <= vin_c[k];
                if (vin_c[k]) begin
                    sum_p[k] <= snext_c[k];
                    cy_p[k]  <= cout_c[k];
                    cm_p[k]  <= cm_c[k];
                end
            end
            if (vin_c[L-1]) zero_p <= (snext_c[L-1] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k < L; k++) begin
                if (vin_c[k]) begin
                    a_p[k] <= sa_c[k];
                    b_p[k] <= sb_c[k];
                end
            end
        end
    end

    assign out_valid = vld_p[L-1];
    assign sum       = sum_p[L-1];
    assign cout      = cy_p[L-1];
    assign ovf       = cm_p[L-1] ^ cy_p[L-1];
    assign zero      = zero_p;

endmodule

// File: tb/tb_sumator_cla_pipe.sv
// Directed and reference-model bench for the pipelined lookahead adder.
module tb_sumator_cla_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
    logic [15:0] a, b, sum;

    logic        in_valid2, in_ready2, sub2, out_valid2, out_ready2, cout2, ovf2, zero2;
    logic [31:0] a2, b2, sum2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sumator_cla_pipe #(.WIDTH(16), .STAGE_BITS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    sumator_cla_pipe #(.WIDTH(32), .STAGE_BITS(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vs, input logic [15:0] es, input logic ec,
                           input logic eo, input logic ez);
        a = va; b = vb; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        #1;
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_zero"}, zero, ez);
        tick();
    endtask

    logic [15:0] bp_a [6];
    logic [15:0] bp_b [6];
    logic        bp_s [6];
    logic [15:0] bp_e [6];
    logic [34:0] q [$];

    initial begin
        int          sent, rcvd, cyc;
        logic [15:0] held;
        logic        stalled_prev;
        logic [31:0] bop;
        logic [32:0] full;
        logic        eo;

        bp_a = '{16'h0001, 16'h1234, 16'h00FF, 16'hFFFF, 16'h1000, 16'h0F0F};
        bp_b = '{16'h0002, 16'h1111, 16'h0001, 16'h0002, 16'h0001, 16'hF0F0};
        bp_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bp_e = '{16'h0003, 16'h2345, 16'h0100, 16'h0001, 16'h0FFF, 16'hFFFF};

        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; sub2 = 1'b0;

        // Reset with junk on the inputs
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'($urandom);
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        #1;
        chk("rst_vld_async", out_valid, 0);
        chk("rst_rdy_async", in_ready, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_vld", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, zero}, 0);
        chk("rst_rdy", in_ready, 1);
        in_valid = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            tick();
            chk("post_rst_out", {out_valid, cout, ovf, zero, sum}, 0);
        end

        run_one("cross",  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_one("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_one("subovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_one("subneg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_one("addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_one("subz",   16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream with a 3-cycle consumer stall
        sent = 0; rcvd = 0; cyc = 0; held = '0; stalled_prev = 1'b0;
        while (rcvd < 6 && cyc < 40) begin
            in_valid = (sent < 6);
            if (sent < 6) begin
                a = bp_a[sent]; b = bp_b[sent]; sub = bp_s[sent];
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (out_valid && !out_ready) begin
                chk("bp_inrdy", in_ready, 0);
                if (stalled_prev) chk("bp_hold", sum, held);
                held = sum;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("bp_seq", sum, bp_e[rcvd]);
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", rcvd, 6);
        #1;
        chk("bp_drain", out_valid, 0);

        // Reset with two beats in flight
        tick();
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0;
        tick();
        a = 16'h0002;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("rst_mid_pre", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_vld", out_valid, 0);
        chk("rst_mid_sum", sum, 0);
        chk("rst_mid_rdy", in_ready, 1);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_stale", out_valid, 0);
        end

        // 32-bit, 8-stage instance against a reference model
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 10000 && cyc < 60000) begin
            in_valid2 = (sent < 10000) && ($urandom_range(0, 3) != 0);
            if (sent == 0) begin
                a2 = 32'hFFFF_FFFF; b2 = 32'h1; sub2 = 1'b0;
            end else if (sent == 1) begin
                a2 = 32'h8000_0000; b2 = 32'h1; sub2 = 1'b1;
            end else begin
                a2 = $urandom; b2 = $urandom; sub2 = 1'($urandom);
            end
            out_ready2 = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid2 && out_ready2) begin
                if (q.size() == 0) chk("rnd_extra", 1, 0);
                else chk("rnd", {cout2, ovf2, zero2, sum2}, 64'(q.pop_front()));
                rcvd++;
            end
            if (in_valid2 && in_ready2) begin
                bop  = sub2 ? ~b2 : b2;
                full = {1'b0, a2} + {1'b0, bop} + 33'(sub2);
                if (sub2) eo = (a2[31] != b2[31]) && (full[31] != a2[31]);
                else      eo = (a2[31] == b2[31]) && (full[31] != a2[31]);
                q.push_back({full[32], eo, full[31:0] == 32'h0, full[31:0]});
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid2 = 1'b0;
        chk("rnd_count", rcvd, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
